// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU and loader)
// and the single-ported data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  c_req;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic                  cpu_stall;

    logic                  l_req;
    logic                  l_we;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic                  l_lock;
    logic                  l_gnt;
    logic                  l_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        input  mem_rd,
        output c_gnt, c_rvalid, cpu_stall,
        output l_gnt, l_rvalid, rdata,
        output mem_we, mem_addr, mem_wd
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        output mem_rd,
        input  c_gnt, c_rvalid, cpu_stall,
        input  l_gnt, l_rvalid, rdata,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU memory stage and the
// loader port: one access per cycle, registered read data, bounded loader locking.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_YIELD  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  last_gnt_l_r;
    logic                  last_gnt_l_nxt_s;
    logic [CNT_W-1:0]      lock_cnt_r;
    logic [CNT_W-1:0]      lock_cnt_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  c_rvalid_r;
    logic                  l_rvalid_r;
    logic                  c_gnt_s;
    logic                  l_gnt_s;
    logic                  rd_gnt_s;

    // Grant decision and next-state logic; grants are forced off while reset is asserted.
    always_comb begin
        c_gnt_s          = 1'b0;
        l_gnt_s          = 1'b0;
        state_nxt_s      = state_r;
        lock_cnt_nxt_s   = lock_cnt_r;
        last_gnt_l_nxt_s = last_gnt_l_r;
        if (rst) begin
            case (state_r)
                ST_ARB: begin
                    if (bus.c_req && bus.l_req) begin
                        c_gnt_s = last_gnt_l_r;
                        l_gnt_s = ~last_gnt_l_r;
                    end else begin
                        c_gnt_s = bus.c_req;
                        l_gnt_s = bus.l_req;
                    end
                    if (l_gnt_s && bus.l_lock) begin
                        state_nxt_s    = ST_LOCKED;
                        lock_cnt_nxt_s = CNT_W'(1);
                    end else begin
                        state_nxt_s    = ST_ARB;
                        lock_cnt_nxt_s = '0;
                    end
                    if (c_gnt_s) begin
                        last_gnt_l_nxt_s = 1'b0;
                    end else if (l_gnt_s) begin
                        last_gnt_l_nxt_s = 1'b1;
                    end else begin
                        last_gnt_l_nxt_s = last_gnt_l_r;
                    end
                end
                ST_LOCKED: begin
                    // The releasing cycle still follows the locked grant rule.
                    l_gnt_s = bus.l_req;
                    if (!bus.l_lock) begin
                        state_nxt_s    = ST_ARB;
                        lock_cnt_nxt_s = '0;
                    end else if (lock_cnt_r == CNT_MAX) begin
                        state_nxt_s    = bus.c_req ? ST_YIELD : ST_LOCKED;
                        lock_cnt_nxt_s = lock_cnt_r;
                    end else begin
                        state_nxt_s    = ST_LOCKED;
                        lock_cnt_nxt_s = lock_cnt_r + CNT_W'(1);
                    end
                    if (l_gnt_s) begin
                        last_gnt_l_nxt_s = 1'b1;
                    end else begin
                        last_gnt_l_nxt_s = last_gnt_l_r;
                    end
                end
                ST_YIELD: begin
                    c_gnt_s          = bus.c_req;
                    state_nxt_s      = ST_ARB;
                    lock_cnt_nxt_s   = '0;
                    last_gnt_l_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s    = ST_ARB;
                    lock_cnt_nxt_s = '0;
                end
            endcase
        end else begin
            state_nxt_s    = ST_ARB;
            lock_cnt_nxt_s = '0;
        end
    end

    // Memory port mux driven by whichever port holds the grant.
    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        if (c_gnt_s) begin
            bus.mem_we   = bus.c_we;
            bus.mem_addr = bus.c_addr;
            bus.mem_wd   = bus.c_wdata;
        end else if (l_gnt_s) begin
            bus.mem_we   = bus.l_we;
            bus.mem_addr = bus.l_addr;
            bus.mem_wd   = bus.l_wdata;
        end else begin
            bus.mem_we   = 1'b0;
            bus.mem_addr = '0;
            bus.mem_wd   = '0;
        end
    end

    assign rd_gnt_s = (c_gnt_s && !bus.c_we) || (l_gnt_s && !bus.l_we);

    // Arbitration state, lock counter and registered read-data path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_ARB;
            last_gnt_l_r <= 1'b1;
            lock_cnt_r   <= '0;
            rdata_r      <= '0;
            c_rvalid_r   <= 1'b0;
            l_rvalid_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_gnt_l_r <= last_gnt_l_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
            c_rvalid_r   <= c_gnt_s && !bus.c_we;
            l_rvalid_r   <= l_gnt_s && !bus.l_we;
            if (rd_gnt_s) begin
                rdata_r <= bus.mem_rd;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.c_gnt     = c_gnt_s;
    assign bus.l_gnt     = l_gnt_s;
    assign bus.cpu_stall = bus.c_req & ~c_gnt_s;
    assign bus.c_rvalid  = c_rvalid_r;
    assign bus.l_rvalid  = l_rvalid_r;
    assign bus.rdata     = rdata_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus pushes expected grants and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LM = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory stand-in: unwritten words read back as 0xA50000<addr>.
    logic [DW-1:0] mem [256];
    bit            written [256];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr]     <= bus.mem_wd;
            written[bus.mem_addr] <= 1'b1;
        end
    end
    assign bus.mem_rd = written[bus.mem_addr] ? mem[bus.mem_addr] : {24'hA50000, bus.mem_addr};

    typedef struct {
        bit          port_l;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic        stall;
    } gnt_t;

    typedef struct {
        bit          port_l;
        logic [DW-1:0] data;
    } rd_t;

    gnt_t gnt_q[$];
    rd_t  rd_q[$];
    gnt_t mg;
    rd_t  mr;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever a grant or a read return is presented.
    always @(negedge clk) begin
        if (bus.c_gnt === 1'b1 || bus.l_gnt === 1'b1) begin
            if (gnt_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got c_gnt=%b l_gnt=%b, expected none", bus.c_gnt, bus.l_gnt);
            end else begin
                mg = gnt_q.pop_front();
                check("c_gnt", 64'(bus.c_gnt), 64'(!mg.port_l));
                check("l_gnt", 64'(bus.l_gnt), 64'(mg.port_l));
                check("mem_we", 64'(bus.mem_we), 64'(mg.we));
                check("mem_addr", 64'(bus.mem_addr), 64'(mg.addr));
                check("mem_wd", 64'(bus.mem_wd), 64'(mg.wd));
                check("cpu_stall", 64'(bus.cpu_stall), 64'(mg.stall));
            end
        end
        if (bus.c_rvalid === 1'b1 || bus.l_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got c_rvalid=%b l_rvalid=%b, expected none", bus.c_rvalid, bus.l_rvalid);
            end else begin
                mr = rd_q.pop_front();
                check("c_rvalid", 64'(bus.c_rvalid), 64'(!mr.port_l));
                check("l_rvalid", 64'(bus.l_rvalid), 64'(mr.port_l));
                check("rdata", 64'(bus.rdata), 64'(mr.data));
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic lr, input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic lk);
        bus.c_req   = cr;
        bus.c_we    = cw;
        bus.c_addr  = ca;
        bus.c_wdata = cd;
        bus.l_req   = lr;
        bus.l_we    = lw;
        bus.l_addr  = la;
        bus.l_wdata = ld;
        bus.l_lock  = lk;
    endtask

    // One bus cycle: who = 0 none, 1 C granted, 2 L granted; exp_rd is the hand-computed read data.
    task automatic cyc(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic lr, input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic lk, input int who, input logic [DW-1:0] exp_rd, input bit keep_rd = 1'b1);
        gnt_t g;
        rd_t  r;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(cr, cw, ca, cd, lr, lw, la, ld, lk);
        if (who == 1) begin
            g = '{port_l: 1'b0, we: cw, addr: ca, wd: cd, stall: 1'b0};
            gnt_q.push_back(g);
            if (!cw && keep_rd) begin
                r = '{port_l: 1'b0, data: exp_rd};
                rd_q.push_back(r);
            end
        end else if (who == 2) begin
            g = '{port_l: 1'b1, we: lw, addr: la, wd: ld, stall: cr};
            gnt_q.push_back(g);
            if (!lw && keep_rd) begin
                r = '{port_l: 1'b1, data: exp_rd};
                rd_q.push_back(r);
            end
        end
    endtask

    localparam logic [DW-1:0] Z = 32'h0;

    initial begin
        // Reset held with the CPU requesting: nothing may be granted.
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, Z, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("rst_c_gnt", 64'(bus.c_gnt), 64'd0);
            check("rst_mem_we", 64'(bus.mem_we), 64'd0);
            check("rst_rdata", 64'(bus.rdata), 64'd0);
            check("rst_cpu_stall", 64'(bus.cpu_stall), 64'd1);
        end

        // C write then read-back of the same address.
        cyc(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, Z, 1'b0, 1, Z);
        cyc(1'b1, 1'b0, 8'h10, Z,            1'b0, 1'b0, 8'h00, Z, 1'b0, 1, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 8'h00, Z,            1'b0, 1'b0, 8'h00, Z, 1'b0, 0, Z);

        // Fresh reset, then both ports contend for six cycles: C,L,C,L,C,L.
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, Z, 1'b0, 1'b0, 8'h00, Z, 1'b0);
        @(negedge clk);
        check("rst2_l_gnt", 64'(bus.l_gnt), 64'd0);
        cyc(1'b1, 1'b1, 8'h30, 32'hC0DE0030, 1'b1, 1'b0, 8'h40, Z, 1'b0, 1, Z);
        cyc(1'b1, 1'b1, 8'h31, 32'hC0DE0031, 1'b1, 1'b0, 8'h40, Z, 1'b0, 2, 32'hA5000040);
        cyc(1'b1, 1'b1, 8'h31, 32'hC0DE0031, 1'b1, 1'b0, 8'h41, Z, 1'b0, 1, Z);
        cyc(1'b1, 1'b1, 8'h32, 32'hC0DE0032, 1'b1, 1'b0, 8'h41, Z, 1'b0, 2, 32'hA5000041);
        cyc(1'b1, 1'b1, 8'h32, 32'hC0DE0032, 1'b1, 1'b0, 8'h42, Z, 1'b0, 1, Z);
        cyc(1'b1, 1'b1, 8'h33, 32'hC0DE0033, 1'b1, 1'b0, 8'h42, Z, 1'b0, 2, 32'hA5000042);

        // Lock run: L wins the tie, holds 16 locked cycles, C gets exactly one yield slot.
        cyc(1'b1, 1'b1, 8'h33, 32'hC0DE0033, 1'b1, 1'b1, 8'h50, 32'h10000000, 1'b1, 1, Z);
        cyc(1'b1, 1'b0, 8'h30, Z,            1'b1, 1'b1, 8'h50, 32'h10000000, 1'b1, 2, Z);
        for (int k = 1; k <= LM; k++) begin
            cyc(1'b1, 1'b0, 8'h30, Z, 1'b1, 1'b1, 8'(8'h50 + k), 32'h10000000 + k, 1'b1, 2, Z);
        end
        cyc(1'b1, 1'b0, 8'h30, Z,            1'b1, 1'b1, 8'h60, 32'h10000060, 1'b1, 1, 32'hC0DE0030);
        cyc(1'b1, 1'b1, 8'h70, 32'hC0DE0070, 1'b1, 1'b1, 8'h60, 32'h10000060, 1'b0, 2, Z);
        cyc(1'b1, 1'b1, 8'h70, 32'hC0DE0070, 1'b0, 1'b0, 8'h00, Z,            1'b0, 1, Z);

        // Early release: lock dropped on the fifth locked cycle, C then wins the tie.
        cyc(1'b1, 1'b0, 8'h10, Z, 1'b1, 1'b1, 8'h80, 32'h20000000, 1'b1, 2, Z);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 1'b0, 8'h10, Z, 1'b1, 1'b1, 8'(8'h80 + k), 32'h20000000 + k, (k < 5) ? 1'b1 : 1'b0, 2, Z);
        end
        cyc(1'b1, 1'b0, 8'h10, Z, 1'b1, 1'b0, 8'h81, Z, 1'b0, 1, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 8'h00, Z, 1'b1, 1'b0, 8'h81, Z, 1'b0, 2, 32'h20000001);

        // Async reset in the cycle after a locked L read: rvalid dropped, no write issued.
        cyc(1'b0, 1'b0, 8'h00, Z, 1'b1, 1'b0, 8'h82, Z, 1'b1, 2, Z, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, Z, 1'b1, 1'b1, 8'h90, 32'h30000090, 1'b1);
        check("pre_rst_l_rvalid", 64'(bus.l_rvalid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_l_rvalid", 64'(bus.l_rvalid), 64'd0);
        check("async_l_gnt", 64'(bus.l_gnt), 64'd0);
        check("async_mem_we", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        check("async_mem_we_neg", 64'(bus.mem_we), 64'd0);
        // Released into ARB with last_gnt=L: C must win the tie despite l_lock.
        cyc(1'b1, 1'b1, 8'h91, 32'hC0DE0091, 1'b1, 1'b1, 8'h90, 32'h30000090, 1'b1, 1, Z);
        cyc(1'b0, 1'b0, 8'h00, Z,            1'b1, 1'b0, 8'h90, Z,            1'b0, 2, 32'hA5000090);
        cyc(1'b0, 1'b0, 8'h00, Z,            1'b0, 1'b0, 8'h00, Z,            1'b0, 0, Z);
        cyc(1'b0, 1'b0, 8'h00, Z,            1'b0, 1'b0, 8'h00, Z,            1'b0, 0, Z);
        @(negedge clk);
        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
